// File: rtl/u_rf_sb.sv
// Integer register file (x1..x31) with a per-register pending-write scoreboard.
// Optional write-to-read bypass: define U_RF_SB_BYPASS_EN.
module u_rf_sb #(
    parameter int unsigned CNT_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_a,
    input  logic [4:0]  rs2_a,
    input  logic        rs1_use,
    input  logic        rs2_use,
    output logic [31:0] rf_rs1_o,
    output logic [31:0] rf_rs2_o,
    input  logic        rf_rd_e,
    input  logic [4:0]  rf_rd_a,
    input  logic [31:0] rf_rd_i,
    input  logic        issue_e,
    input  logic [4:0]  issue_a,
    input  logic        issue_kill,
    output logic        stall,
    output logic        sb_err
);

    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);
    localparam logic [SUM_W-1:0] BIAS    = SUM_W'(2);

    logic [31:0]      regs    [31:1];
    logic [CNT_W-1:0] cnt     [31:1];
    logic [CNT_W-1:0] cnt_nxt [31:1];
    logic             li_v;
    logic [4:0]       li_a;
    logic             err_nxt;
    logic [SUM_W-1:0] sum_t;

    logic [31:0]      raw1, raw2;
    logic [CNT_W-1:0] cnt1, cnt2;
    logic             busy1, busy2;

    // Next counter values; the sum is biased by 2 so the -2..+1 delta stays unsigned.
    always_comb begin
        err_nxt = 1'b0;
        sum_t   = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            sum_t = SUM_W'(cnt[r]) + BIAS
                  + SUM_W'(issue_e && (issue_a == 5'(r)))
                  - SUM_W'(rf_rd_e && (rf_rd_a == 5'(r)))
                  - SUM_W'(issue_kill && li_v && (li_a == 5'(r)));
            if (sum_t < BIAS) begin
                cnt_nxt[r] = '0;
                err_nxt    = 1'b1;
            end else if ((sum_t - BIAS) > CNT_MAX) begin
                cnt_nxt[r] = CNT_MAX[CNT_W-1:0];
                err_nxt    = 1'b1;
            end else begin
                cnt_nxt[r] = CNT_W'(sum_t - BIAS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 1; r < 32; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            li_v   <= 1'b0;
            li_a   <= '0;
            sb_err <= 1'b0;
        end else begin
            if (rf_rd_e && (rf_rd_a != 5'd0)) begin
                regs[rf_rd_a] <= rf_rd_i;
            end
            for (int unsigned r = 1; r < 32; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            li_v   <= issue_e && (issue_a != 5'd0);
            li_a   <= issue_a;
            sb_err <= sb_err | err_nxt;
        end
    end

    // Stored view of each read port; x0 reads as zero and is never busy.
    always_comb begin
        raw1 = '0;
        raw2 = '0;
        cnt1 = '0;
        cnt2 = '0;
        if (rs1_a != 5'd0) begin
            raw1 = regs[rs1_a];
            cnt1 = cnt[rs1_a];
        end
        if (rs2_a != 5'd0) begin
            raw2 = regs[rs2_a];
            cnt2 = cnt[rs2_a];
        end
    end

`ifdef U_RF_SB_BYPASS_EN
    logic hit1, hit2, mask1, mask2;

    // A write landing this cycle forwards its data and retires the last pending slot.
    always_comb begin
        hit1     = rf_rd_e && (rf_rd_a == rs1_a) && (rs1_a != 5'd0);
        hit2     = rf_rd_e && (rf_rd_a == rs2_a) && (rs2_a != 5'd0);
        mask1    = hit1 && (cnt1 == CNT_W'(1)) && !(issue_e && (issue_a == rs1_a));
        mask2    = hit2 && (cnt2 == CNT_W'(1)) && !(issue_e && (issue_a == rs2_a));
        rf_rs1_o = hit1 ? rf_rd_i : raw1;
        rf_rs2_o = hit2 ? rf_rd_i : raw2;
        busy1    = (cnt1 != '0) && !mask1;
        busy2    = (cnt2 != '0) && !mask2;
    end
`else
    always_comb begin
        rf_rs1_o = raw1;
        rf_rs2_o = raw2;
        busy1    = (cnt1 != '0);
        busy2    = (cnt2 != '0);
    end
`endif

    assign stall = (rs1_use && busy1) || (rs2_use && busy2);

endmodule

// File: tb/tb_u_rf_sb.sv
// Directed vector bench for u_rf_sb; expectations follow U_RF_SB_BYPASS_EN if defined.
module tb_u_rf_sb;

`ifdef U_RF_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_a, rs2_a;
    logic        rs1_use, rs2_use;
    logic [31:0] rf_rs1_o, rf_rs2_o;
    logic        rf_rd_e;
    logic [4:0]  rf_rd_a;
    logic [31:0] rf_rd_i;
    logic        issue_e;
    logic [4:0]  issue_a;
    logic        issue_kill;
    logic        stall, sb_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    u_rf_sb #(.CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .rs1_a(rs1_a), .rs2_a(rs2_a), .rs1_use(rs1_use), .rs2_use(rs2_use),
        .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o),
        .rf_rd_e(rf_rd_e), .rf_rd_a(rf_rd_a), .rf_rd_i(rf_rd_i),
        .issue_e(issue_e), .issue_a(issue_a), .issue_kill(issue_kill),
        .stall(stall), .sb_err(sb_err)
    );

    typedef struct {
        bit        rst;
        bit [4:0]  rs1_a;
        bit        rs1_use;
        bit [4:0]  rs2_a;
        bit        rs2_use;
        bit        rd_e;
        bit [4:0]  rd_a;
        bit [31:0] rd_i;
        bit        iss_e;
        bit [4:0]  iss_a;
        bit        kill;
        bit [31:0] e_rs1;
        bit [31:0] e_rs2;
        bit        e_stall;
        bit        e_err;
        bit        chk;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit [4:0] a1, bit u1, bit [4:0] a2, bit u2,
                                bit we, bit [4:0] wa, bit [31:0] wd,
                                bit ie, bit [4:0] ia, bit k,
                                bit [31:0] e1, bit [31:0] e2, bit es, bit ee, bit c);
        vec_t v;
        v.rst = r; v.rs1_a = a1; v.rs1_use = u1; v.rs2_a = a2; v.rs2_use = u2;
        v.rd_e = we; v.rd_a = wa; v.rd_i = wd;
        v.iss_e = ie; v.iss_a = ia; v.kill = k;
        v.e_rs1 = e1; v.e_rs2 = e2; v.e_stall = es; v.e_err = ee; v.chk = c;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; rs1_a = v.rs1_a; rs1_use = v.rs1_use; rs2_a = v.rs2_a; rs2_use = v.rs2_use;
        rf_rd_e = v.rd_e; rf_rd_a = v.rd_a; rf_rd_i = v.rd_i;
        issue_e = v.iss_e; issue_a = v.iss_a; issue_kill = v.kill;
    endtask

    // Apply one vector for one cycle; outputs are sampled mid-cycle on the falling edge.
    task automatic run(input vec_t v, input int idx);
        drive(v);
        @(negedge clk);
        if (v.chk) begin
            check("rs1", idx, rf_rs1_o, v.e_rs1);
            check("rs2", idx, rf_rs2_o, v.e_rs2);
            check("stall", idx, 32'(stall), 32'(v.e_stall));
            check("sb_err", idx, 32'(sb_err), 32'(v.e_err));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, preload, x0 handling, kill with no prior issue
        vecs.push_back(mk(1, 0,0, 0,0, 0,0,0,            0,0,0, 0,0,0,0, 0));
        vecs.push_back(mk(0, 5,0, 0,0, 1,5,32'h1234,     0,0,0, BYP ? 32'h1234 : 32'h0,0,0,0, 1));
        vecs.push_back(mk(1, 5,1, 0,0, 0,0,0,            0,0,0, 32'h1234,0,0,1, 1));
        vecs.push_back(mk(0, 5,0, 0,0, 1,0,32'hFFFFFFFF, 0,0,0, 0,0,0,0, 1));
        vecs.push_back(mk(0, 0,1, 0,0, 0,0,0,            1,0,0, 0,0,0,0, 1));
        vecs.push_back(mk(0, 0,1, 0,0, 0,0,0,            0,0,1, 0,0,0,0, 1));
        // RAW on x7
        vecs.push_back(mk(0, 7,1, 0,0, 0,0,0,            1,7,0, 0,0,0,0, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 7,1, 0,0, 0,0,0,        0,0,0, 0,0,1,0, 1));
        vecs.push_back(mk(0, 7,1, 0,0, 1,7,32'hA5A5A5A5, 0,0,0, BYP ? 32'hA5A5A5A5 : 32'h0,0,!BYP,0, 1));
        vecs.push_back(mk(0, 7,1, 0,0, 0,0,0,            0,0,0, 32'hA5A5A5A5,0,0,0, 1));
        // Kill on x9
        vecs.push_back(mk(0, 0,0, 9,1, 0,0,0,            1,9,0, 0,0,0,0, 1));
        vecs.push_back(mk(0, 0,0, 9,1, 0,0,0,            0,0,1, 0,0,1,0, 1));
        vecs.push_back(mk(0, 0,0, 9,1, 0,0,0,            0,0,0, 0,0,0,0, 1));
        // Simultaneous issue and write on x3
        vecs.push_back(mk(0, 3,1, 0,0, 0,0,0,            1,3,0, 0,0,0,0, 1));
        vecs.push_back(mk(0, 3,1, 0,0, 1,3,32'h33,       1,3,0, BYP ? 32'h33 : 32'h0,0,1,0, 1));
        vecs.push_back(mk(0, 3,1, 0,0, 0,0,0,            0,0,0, 32'h33,0,1,0, 1));
        vecs.push_back(mk(0, 3,1, 0,0, 1,3,32'h34,       0,0,0, BYP ? 32'h34 : 32'h33,0,!BYP,0, 1));
        vecs.push_back(mk(0, 3,1, 0,0, 0,0,0,            0,0,0, 32'h34,0,0,0, 1));
        // Eight issues to x4 saturate at 7, then seven writes drain it
        vecs.push_back(mk(0, 0,0, 4,1, 0,0,0,            1,4,0, 0,0,0,0, 1));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0, 0,0, 4,1, 0,0,0,        1,4,0, 0,0,1,0, 1));
        vecs.push_back(mk(0, 0,0, 4,1, 0,0,0,            0,0,0, 0,0,1,1, 1));
        vecs.push_back(mk(0, 0,0, 4,1, 1,4,32'h44,       0,0,0, 0,BYP ? 32'h44 : 32'h0,1,1, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0,0, 4,1, 1,4,32'h44,   0,0,0, 0,32'h44,1,1, 1));
        vecs.push_back(mk(0, 0,0, 4,1, 1,4,32'h44,       0,0,0, 0,32'h44,!BYP,1, 1));
        vecs.push_back(mk(0, 0,0, 4,1, 0,0,0,            0,0,0, 0,32'h44,0,1, 1));
        // Underflow from a write with nothing pending
        vecs.push_back(mk(1, 0,0, 4,0, 0,0,0,            0,0,0, 0,32'h44,0,1, 1));
        vecs.push_back(mk(0, 10,1, 4,0, 1,10,32'hBEEF,   0,0,0, BYP ? 32'hBEEF : 32'h0,0,0,0, 1));
        vecs.push_back(mk(0, 10,1, 0,0, 0,0,0,           0,0,0, 32'hBEEF,0,0,1, 1));

        drive(mk(1, 0,0, 0,0, 0,0,0, 0,0,0, 0,0,0,0, 0));
        @(posedge clk);
        #1;
        foreach (vecs[i]) run(vecs[i], i);

        // Kill and write on the same register in one cycle: net -2 from cnt=2
        run(mk(1, 0,0, 0,0, 0,0,0,           0,0,0,  0,0,0,0, 0), 100);
        run(mk(0, 12,1, 0,0, 0,0,0,          1,12,0, 0,0,0,0, 1), 101);
        run(mk(0, 12,1, 0,0, 0,0,0,          1,12,0, 0,0,1,0, 1), 102);
        run(mk(0, 12,1, 0,0, 1,12,32'h1200,  0,0,1,  BYP ? 32'h1200 : 32'h0,0,1,0, 1), 103);
        run(mk(0, 12,1, 0,0, 0,0,0,          0,0,0,  32'h1200,0,0,0, 1), 104);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/u_rf_sb.md
# u_rf_sb

Integer register file with a pending-write scoreboard. It consumes the delayed writeback stream (`rf_rd_e`/`rf_rd_a`/`rf_rd_i`) produced by the execute stage and supplies the `rf_rs1_o`/`rf_rs2_o` operands that decode registers into execute. It also tracks destination registers reserved by issued instructions whose writes are still in the execute writeback buffer, and raises `stall` when a reader depends on one of them.

## Interface
- `CNT_W`, default 3: width of each per-register pending counter. Maximum in-flight writes per register is 2^CNT_W−1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rs1_a`  in  5  read address, port 1.
- `rs2_a`  in  5  read address, port 2.
- `rs1_use`  in  1  current decode instruction reads rs1.
- `rs2_use`  in  1  current decode instruction reads rs2.
- `rf_rs1_o`  out  32  read data, port 1 (combinational).
- `rf_rs2_o`  out  32  read data, port 2 (combinational).
- `rf_rd_e`  in  1  write enable from execute writeback.
- `rf_rd_a`  in  5  write address.
- `rf_rd_i`  in  32  write data.
- `issue_e`  in  1  instruction with a destination register enters execute this cycle.
- `issue_a`  in  5  destination register being reserved.
- `issue_kill`  in  1  cancels the reservation made by the previous cycle's issue (execute input flush).
- `stall`  out  1  decode must hold because a used source is pending.
- `sb_err`  out  1  sticky error flag: counter overflow or underflow.

## Operation
- Storage: 31 × 32-bit registers x1..x31. x0 is not stored; reads of address 0 return 0, writes to address 0 are discarded.
- Write: if `rf_rd_e` and `rf_rd_a`≠0, `regs[rf_rd_a] <= rf_rd_i` at the clock edge.
- Read: `rf_rsN_o = regs[rsN_a]`, combinational. See Configuration for same-cycle bypass.
- Last-issue register: `li_v <= issue_e & issue_a≠0`, `li_a <= issue_a`, updated every cycle.
- Pending counter `cnt[r]` for r = 1..31. The net delta per edge is the sum of:
  - +1 if `issue_e` and `issue_a`=r;
  - −1 if `rf_rd_e` and `rf_rd_a`=r;
  - −1 if `issue_kill`, `li_v`, and `li_a`=r.
- Any combination of these events may hit the same register in one cycle. The net delta is applied once, with a range of −2..+1.
- Overflow: if the counter would exceed 2^CNT_W−1, it saturates at max and `sb_err` is set.
- Underflow: if the counter would go below 0, it clamps to 0 and `sb_err` is set. The register write is still performed.
- `busyN` = (`rsN_a`≠0) & (`cnt[rsN_a]`≠0), after the bypass mask described in Configuration.
- `stall` = (`rs1_use` & `busy1`) | (`rs2_use` & `busy2`).
- `issue_kill` with `li_v`=0 has no effect and does not raise an error.
- `sb_err` clears only on `rst`.

## Timing
- Reset (`rst`=1 at an edge): all registers become 0, all `cnt` become 0, `li_v`=0, `sb_err`=0. Consequently `rf_rs1_o`/`rf_rs2_o`=0, `stall`=0, `sb_err`=0 in the following cycle.
- Reset overrides all simultaneous writes, issues, and kills. Reset in the middle of in-flight operations discards them.
- Read latency is 0 cycles (combinational from address). Write latency is 1 edge.
- A counter increment from issue in cycle N is visible to `stall` in cycle N+1.
- A decrement from a write in cycle N is visible in N+1. With the bypass feature, the effect of that write is visible in N itself.
- `stall` is purely combinational. It is not registered here; decode applies it.

## Configuration
- Macro: `U_RF_SB_BYPASS_EN`.
- Defined: write-to-read bypass.
  - If `rf_rd_e` & `rf_rd_a`=`rsN_a`≠0, then `rf_rsN_o`=`rf_rd_i` in the same cycle.
  - `busyN` is masked to 0 when, in addition, `cnt[rsN_a]`=1 and no issue to that register is counted this cycle.
- Undefined: no bypass.
  - Reads return the pre-edge value.
  - `busyN` follows `cnt` only, so a dependent reader stalls one extra cycle.

## Test plan
- Reset: preload x5=0x1234 by write, then assert `rst` → `rf_rs1_o`(x5)=0, `stall`=0, `sb_err`=0 next cycle.
- x0: write x0=0xFFFFFFFF, then issue `issue_a`=0 → `rf_rs1_o`(x0)=0, `stall` never asserts with `rs1_use`=1.
- Scoreboard RAW sequence:
  - Issue x7 in cycle 0. Read x7 with `rs1_use` in cycles 1–3 → `stall`=1.
  - Write x7=0xA5A5A5A5 in cycle 4.
  - With bypass: `stall`=0 and `rf_rs1_o`=0xA5A5A5A5 in cycle 4.
  - Without bypass: the same response occurs in cycle 5.
- Kill: issue x9 in cycle 0, `issue_kill` in cycle 1 → `cnt[x9]`=0 and `stall`=0 for an x9 read in cycle 2.
- Simultaneous events: `cnt[x3]`=1; in one cycle issue x3 and write x3 → cnt stays 1 and `stall` stays 1 for an x3 read (bypass mask not applied).
- Error: 8 issues to x4 with no writes (CNT_W=3) → cnt saturates at 7, `sb_err`=1. Also: a write to x10 with cnt=0 → data written, `sb_err`=1.
